// File: rtl/mul_div_unit.sv
// HI/LO owning multi-cycle multiply/divide unit for the execute stage.
// Optional SPECIAL2 multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MADD_EN.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruc,
    input  logic [31:0] MD_A,
    input  logic [31:0] MD_B,
    input  logic        interrupt,
    output logic        start,
    output logic [4:0]  busyCnt,
    output logic [31:0] HLRe
);
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_we;
    logic [4:0]  r_busy;

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic        w_special;
    logic        w_mult;
    logic        w_multu;
    logic        w_div;
    logic        w_divu;
    logic        w_mfhi;
    logic        w_mflo;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_madd;
    logic        w_maddu;
    logic        w_msub;
    logic        w_msubu;
    logic        w_unused_fields;

    assign w_op      = instruc[31:26];
    assign w_fn      = instruc[5:0];
    assign w_special = (w_op == OP_SPECIAL);
    assign w_mult    = w_special && (w_fn == FN_MULT);
    assign w_multu   = w_special && (w_fn == FN_MULTU);
    assign w_div     = w_special && (w_fn == FN_DIV);
    assign w_divu    = w_special && (w_fn == FN_DIVU);
    assign w_mfhi    = w_special && (w_fn == FN_MFHI);
    assign w_mflo    = w_special && (w_fn == FN_MFLO);
    assign w_mthi    = w_special && (w_fn == FN_MTHI);
    assign w_mtlo    = w_special && (w_fn == FN_MTLO);
    assign w_unused_fields = ^instruc[25:6];

`ifdef MADD_EN
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    assign w_madd  = (w_op == OP_SPECIAL2) && (w_fn == 6'h00);
    assign w_maddu = (w_op == OP_SPECIAL2) && (w_fn == 6'h01);
    assign w_msub  = (w_op == OP_SPECIAL2) && (w_fn == 6'h04);
    assign w_msubu = (w_op == OP_SPECIAL2) && (w_fn == 6'h05);
`else
    assign w_madd  = 1'b0;
    assign w_maddu = 1'b0;
    assign w_msub  = 1'b0;
    assign w_msubu = 1'b0;
`endif

    assign start   = w_mult | w_multu | w_div | w_divu | w_madd | w_maddu | w_msub | w_msubu;
    assign busyCnt = r_busy;
    assign HLRe    = w_mfhi ? r_hi : (w_mflo ? r_lo : 32'h0);

    // Product and quotient datapaths evaluated on the forwarded operands
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [63:0]        w_acc;
    logic               w_div_ovf;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_b_u;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;

    assign w_prod_s = $signed({{32{MD_A[31]}}, MD_A}) * $signed({{32{MD_B[31]}}, MD_B});
    assign w_prod_u = {32'h0, MD_A} * {32'h0, MD_B};
    assign w_acc    = {r_hi, r_lo};

    // Zero divisors and the -2^31 / -1 overflow both divide by 1 instead;
    // for the overflow case that directly yields quotient 0x80000000, remainder 0.
    assign w_div_ovf = (MD_A == 32'h8000_0000) && (MD_B == 32'hFFFF_FFFF);
    assign w_a_s     = $signed(MD_A);
    assign w_b_s     = ((MD_B == 32'h0) || w_div_ovf) ? 32'sd1 : $signed(MD_B);
    assign w_quo_s   = w_a_s / w_b_s;
    assign w_rem_s   = w_a_s % w_b_s;
    assign w_b_u     = (MD_B == 32'h0) ? 32'd1 : MD_B;
    assign w_quo_u   = MD_A / w_b_u;
    assign w_rem_u   = MD_A % w_b_u;

    logic [63:0] w_res;
    logic        w_res_we;
    logic [4:0]  w_lat;

    always_comb begin
        w_res    = w_prod_s;
        w_res_we = 1'b1;
        w_lat    = 5'(MUL_CYCLES);
        if (w_multu) begin
            w_res = w_prod_u;
        end else if (w_div) begin
            w_res    = {w_rem_s, w_quo_s};
            w_res_we = (MD_B != 32'h0);
            w_lat    = 5'(DIV_CYCLES);
        end else if (w_divu) begin
            w_res    = {w_rem_u, w_quo_u};
            w_res_we = (MD_B != 32'h0);
            w_lat    = 5'(DIV_CYCLES);
        end else if (w_madd) begin
            w_res = w_acc + w_prod_s;
        end else if (w_maddu) begin
            w_res = w_acc + w_prod_u;
        end else if (w_msub) begin
            w_res = w_acc - w_prod_s;
        end else if (w_msubu) begin
            w_res = w_acc - w_prod_u;
        end
    end

    // An in-flight op always runs to commit; only idle-cycle actions honour interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi      <= 32'h0;
            r_lo      <= 32'h0;
            r_pend_hi <= 32'h0;
            r_pend_lo <= 32'h0;
            r_pend_we <= 1'b0;
            r_busy    <= 5'd0;
        end else if (r_busy != 5'd0) begin
            r_busy <= r_busy - 5'd1;
            if ((r_busy == 5'd1) && r_pend_we) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (!interrupt) begin
            if (start) begin
                r_busy    <= w_lat;
                r_pend_hi <= w_res[63:32];
                r_pend_lo <= w_res[31:0];
                r_pend_we <= w_res_we;
            end else if (w_mthi) begin
                r_hi <= MD_A;
            end else if (w_mtlo) begin
                r_lo <= MD_A;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: mult/div arithmetic, busy countdown, interrupt, reset, MADD_EN.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruc;
    logic [31:0] MD_A;
    logic [31:0] MD_B;
    logic        interrupt;
    logic        start;
    logic [4:0]  busyCnt;
    logic [31:0] HLRe;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MFHI  = 32'h0000_0010;
    localparam logic [31:0] MTHI  = 32'h0000_0011;
    localparam logic [31:0] MFLO  = 32'h0000_0012;
    localparam logic [31:0] MTLO  = 32'h0000_0013;
    localparam logic [31:0] MULT  = 32'h0000_0018;
    localparam logic [31:0] MULTU = 32'h0000_0019;
    localparam logic [31:0] DIV   = 32'h0000_001A;
    localparam logic [31:0] DIVU  = 32'h0000_001B;
    localparam logic [31:0] MADDU = 32'h7000_0001;

    mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .instruc(instruc), .MD_A(MD_A), .MD_B(MD_B),
        .interrupt(interrupt), .start(start), .busyCnt(busyCnt), .HLRe(HLRe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        instruc = MFHI;
        #1 chk({tag, " HI"}, HLRe, hi);
        instruc = MFLO;
        #1 chk({tag, " LO"}, HLRe, lo);
        instruc = NOP;
    endtask

    task automatic wr(input logic [31:0] ins, input logic [31:0] a, input logic intr);
        instruc = ins;
        MD_A = a;
        interrupt = intr;
        tick();
        instruc = NOP;
        interrupt = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input int cycles);
        instruc = ins;
        MD_A = a;
        MD_B = b;
        #1 chk({tag, " start"}, {31'h0, start}, 32'h1);
        tick();
        chk({tag, " busy launch"}, {27'h0, busyCnt}, 32'(cycles));
        instruc = NOP;
        for (int i = cycles - 1; i >= 0; i--) begin
            tick();
            chk({tag, " busy"}, {27'h0, busyCnt}, 32'(i));
        end
    endtask

    initial begin
        reset = 1'b1;
        instruc = NOP;
        MD_A = 32'h0;
        MD_B = 32'h0;
        interrupt = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset busy", {27'h0, busyCnt}, 32'h0);
        chk_hilo("reset", 32'h0, 32'h0);

        run_op("mult", MULT, 32'hFFFF_FFFE, 32'd3, 5);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 10);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("divu", DIVU, 32'd7, 32'd2, 10);
        chk_hilo("divu", 32'h1, 32'h3);

        run_op("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        chk_hilo("divovf", 32'h0, 32'h8000_0000);

        wr(MTHI, 32'h1234, 1'b0);
        wr(MTLO, 32'h5678, 1'b0);
        chk_hilo("mthi/mtlo", 32'h1234, 32'h5678);
        run_op("divu0", DIVU, 32'd5, 32'd0, 10);
        chk_hilo("divu0", 32'h1234, 32'h5678);

        // launch cancelled by interrupt
        instruc = MULTU;
        MD_A = 32'd2;
        MD_B = 32'd3;
        interrupt = 1'b1;
        #1 chk("multu irq start", {31'h0, start}, 32'h1);
        tick();
        interrupt = 1'b0;
        instruc = NOP;
        chk("multu irq busy", {27'h0, busyCnt}, 32'h0);
        chk_hilo("multu irq", 32'h1234, 32'h5678);
        wr(MTHI, 32'hAAAA, 1'b1);
        chk_hilo("mthi irq", 32'h1234, 32'h5678);

        // interrupt mid-flight, plus a relaunch attempt while busy
        instruc = MULT;
        MD_A = 32'd3;
        MD_B = 32'd4;
        tick();
        chk("mirq busy5", {27'h0, busyCnt}, 32'd5);
        instruc = NOP;
        tick();
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        chk("mirq busy3", {27'h0, busyCnt}, 32'd3);
        instruc = MULT;
        MD_A = 32'd100;
        MD_B = 32'd100;
        tick();
        instruc = NOP;
        chk("relaunch busy2", {27'h0, busyCnt}, 32'd2);
        tick();
        chk("mirq busy1", {27'h0, busyCnt}, 32'd1);
        chk_hilo("mirq precommit", 32'h1234, 32'h5678);
        tick();
        chk("mirq busy0", {27'h0, busyCnt}, 32'd0);
        chk_hilo("mirq", 32'h0, 32'd12);

        // reset mid-operation discards the pending result
        wr(MTLO, 32'h77, 1'b0);
        instruc = MULT;
        MD_A = 32'd5;
        MD_B = 32'd5;
        tick();
        instruc = NOP;
        tick();
        tick();
        chk("rst busy3", {27'h0, busyCnt}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst busy0", {27'h0, busyCnt}, 32'd0);
        chk_hilo("rst", 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("rst idle busy", {27'h0, busyCnt}, 32'd0);
        chk_hilo("rst nocommit", 32'h0, 32'h0);

        wr(MTHI, 32'h0, 1'b0);
        wr(MTLO, 32'hFFFF_FFFF, 1'b0);
`ifdef MADD_EN
        run_op("maddu", MADDU, 32'd1, 32'd1, 5);
        chk_hilo("maddu", 32'h1, 32'h0);
`else
        instruc = MADDU;
        MD_A = 32'd1;
        MD_B = 32'd1;
        #1 chk("maddu off start", {31'h0, start}, 32'h0);
        tick();
        instruc = NOP;
        chk("maddu off busy", {27'h0, busyCnt}, 32'h0);
        chk_hilo("maddu off", 32'h0, 32'hFFFF_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
